// File: rtl/full_adder.sv
// full_adder: ripple-carry adder with zero-latency combinational sum/carry
// and an optional enabled output register that also records signed overflow.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q
);

  // Carry into the most significant bit; overflow compares it with cout.
  logic msb_carry_in;
  logic ovf;

  // Bit-serial ripple: a running carry walks from bit 0 to the MSB so no
  // carry vector feeds back on itself, and the carry into the MSB is kept.
  always_comb begin
    logic carry;
    sum          = '0;
    carry        = cin;
    msb_carry_in = cin;
    for (int i = 0; i < WIDTH; i++) begin
      msb_carry_in = carry;
      sum[i]       = a[i] ^ b[i] ^ carry;
      carry        = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

  // Signed overflow: carry into and out of the sign bit disagree.
  assign ovf = cout ^ msb_carry_in;

  // Output register stage: cleared asynchronously, loaded only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench for full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       a1, b1, cin1;
  logic [7:0] a8, b8;
  logic       cin8;

  logic       sum1, cout1, sum_q1, cout_q1, ovf_q1;
  logic [7:0] sum8, sum_q8;
  logic       cout8, cout_q8, ovf_q8;

  full_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .en(en),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .ovf_q(ovf_q1)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .en(en),
    .sum(sum8), .cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8), .ovf_q(ovf_q8)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Expected responses are packed as {ovf, cout, sum[7:0]}.
  typedef struct {
    string      name;
    int         sel;
    bit         is_reg;
    logic [9:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  event       chk_ev;
  int         checks = 0;
  int         errors = 0;
  logic [9:0] model_q1, model_q8;

  // Reference arithmetic: unsigned sum and carry from plain addition,
  // overflow from whether the two's-complement result fits in w bits.
  function automatic logic [9:0] ref_add(int w, logic [7:0] a, logic [7:0] b, logic ci);
    longint     m, ua, ub, t, sa, sb, st;
    logic       ov, co;
    logic [7:0] s;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    t  = ua + ub + longint'(ci);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    st = sa + sb + longint'(ci);
    ov = (st >= m / 2) || (st < -(m / 2));
    co = (t >= m);
    s  = 8'(t % m);
    return {ov, co, s};
  endfunction

  // Behavioural model of the output registers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q1 <= '0;
      model_q8 <= '0;
    end else if (en) begin
      model_q1 <= ref_add(1, {7'b0, a1}, {7'b0, b1}, cin1);
      model_q8 <= ref_add(8, a8, b8, cin8);
    end
  end

  function automatic logic [9:0] actual(int sel, bit is_reg);
    if (sel == 1)
      return is_reg ? {ovf_q1, cout_q1, 7'b0, sum_q1} : {1'b0, cout1, 7'b0, sum1};
    else
      return is_reg ? {ovf_q8, cout_q8, sum_q8} : {1'b0, cout8, sum8};
  endfunction

  // Monitor: whenever outputs are presented, drain and compare the scoreboard.
  initial begin
    exp_t       e;
    logic [9:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = actual(e.sel, e.is_reg);
        checks++;
        if (e.is_reg ? (act !== e.exp) : (act[8:0] !== e.exp[8:0])) begin
          errors++;
          $display("[TB] FAIL %s (w%0d): got {ovf,cout,sum}=%h expected %h",
                   e.name, (e.sel == 1) ? 1 : 8, act, e.exp);
        end
      end
    end
  end

  task automatic push_exp(string name, int sel, bit is_reg, logic [9:0] exp);
    exp_t e;
    e.name   = name;
    e.sel    = sel;
    e.is_reg = is_reg;
    e.exp    = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic apply_stimulus(logic [7:0] va, logic [7:0] vb, logic vc, int sel);
    if (sel == 1) begin
      a1 = va[0]; b1 = vb[0]; cin1 = vc;
    end else begin
      a8 = va; b8 = vb; cin8 = vc;
    end
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_exp [8];
  logic [9:0] e1, e8;

  initial begin
    tt_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    rst_n = 1'b0;
    en    = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0;
    a8 = 0; b8 = 0; cin8 = 0;
    #2;
    push_exp("reset_q1", 1, 1, 10'h000);
    push_exp("reset_q8", 8, 1, 10'h000);
    push_exp("zero_comb8", 8, 0, 10'h000);
    check_output();

    // Registers must stay clear during reset even with en and clock.
    en = 1'b1;
    apply_stimulus(8'h1, 8'h1, 1'b1, 1);
    apply_stimulus(8'hFF, 8'hFF, 1'b1, 8);
    clock_edge();
    push_exp("reset_hold_q1", 1, 1, 10'h000);
    push_exp("reset_hold_q8", 8, 1, 10'h000);
    push_exp("allones_comb8", 8, 0, {1'b0, 1'b1, 8'hFF});
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Truth table, each row held 10 time units.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      apply_stimulus({7'b0, v[2]}, {7'b0, v[1]}, v[0], 1);
      push_exp($sformatf("truth_%0d%0d%0d", v[2], v[1], v[0]), 1, 0,
               {1'b0, tt_exp[i][0], 7'b0, tt_exp[i][1]});
      check_output();
      #8;
    end

    // Async reset between clock edges.
    @(negedge clk);
    apply_stimulus(8'h1, 8'h1, 1'b1, 1);
    en = 1'b1;
    clock_edge();
    push_exp("capture_111", 1, 1, {1'b0, 1'b1, 8'h01});
    check_output();
    rst_n = 1'b0;
    push_exp("async_clear_q1", 1, 1, 10'h000);
    push_exp("async_clear_q8", 8, 1, 10'h000);
    push_exp("comb_during_reset", 1, 0, {1'b0, 1'b1, 8'h01});
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Enable hold.
    @(negedge clk);
    apply_stimulus(8'h0, 8'h1, 1'b0, 1);
    en = 1'b1;
    clock_edge();
    push_exp("capture_010", 1, 1, {1'b0, 1'b0, 8'h01});
    check_output();
    @(negedge clk);
    apply_stimulus(8'h1, 8'h1, 1'b1, 1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clock_edge();
      push_exp($sformatf("hold_%0d", k), 1, 1, {1'b0, 1'b0, 8'h01});
      check_output();
    end
    @(negedge clk);
    en = 1'b1;
    clock_edge();
    push_exp("reenable", 1, 1, {1'b0, 1'b1, 8'h01});
    check_output();

    // Overflow at WIDTH=1.
    @(negedge clk);
    apply_stimulus(8'h1, 8'h1, 1'b0, 1);
    clock_edge();
    push_exp("ovf_110", 1, 1, {1'b1, 1'b1, 8'h00});
    check_output();
    @(negedge clk);
    apply_stimulus(8'h0, 8'h0, 1'b1, 1);
    clock_edge();
    push_exp("ovf_001", 1, 1, {1'b1, 1'b0, 8'h01});
    check_output();

    // Wide ripple and boundaries at WIDTH=8.
    @(negedge clk);
    apply_stimulus(8'hFF, 8'h00, 1'b1, 8);
    push_exp("ripple_comb8", 8, 0, {1'b0, 1'b1, 8'h00});
    check_output();
    clock_edge();
    push_exp("ripple_q8", 8, 1, {1'b0, 1'b1, 8'h00});
    check_output();
    @(negedge clk);
    apply_stimulus(8'h7F, 8'h01, 1'b0, 8);
    push_exp("ovf_comb8", 8, 0, {1'b0, 1'b0, 8'h80});
    check_output();
    clock_edge();
    push_exp("ovf_q8", 8, 1, {1'b1, 1'b0, 8'h80});
    check_output();
    @(negedge clk);
    apply_stimulus(8'h00, 8'h00, 1'b0, 8);
    push_exp("zeros_comb8", 8, 0, 10'h000);
    check_output();

    // Random regression against the reference model.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 1);
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom), 8);
      en = ($urandom_range(0, 3) != 0);
      e1 = ref_add(1, {7'b0, a1}, {7'b0, b1}, cin1);
      e8 = ref_add(8, a8, b8, cin8);
      push_exp("rand_comb1", 1, 0, e1);
      push_exp("rand_comb8", 8, 0, e8);
      check_output();
      clock_edge();
      push_exp("rand_q1", 1, 1, model_q1);
      push_exp("rand_q8", 8, 1, model_q8);
      check_output();
    end

    check_output();
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Ripple-carry full adder. Default WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> sum, cout).
- Combinational sum/carry outputs with zero latency.
- Optional registered copy of the result for pipelined datapaths, enabled per cycle.
- Leaf arithmetic cell used by wider adder/ALU blocks.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock; used only by the output register stage.
- rst_n  input  1  asynchronous active-low reset; clears the registered outputs only.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in.
- sum  output  WIDTH  combinational sum, (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry out, bit WIDTH of a+b+cin.
- en  input  1  load enable for the registered outputs.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry out.
- ovf_q  output  1  registered signed overflow flag.

Behaviour:
- Combinational path:
  - {cout, sum} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
  - Bit-level equations: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0] = cin; cout = c[WIDTH].
  - Zero cycles latency. sum and cout depend only on a, b and cin, and are independent of clk, rst_n and en.
  - sum and cout settle within the same delta/timestep after any input change.
  - Must be X-free whenever the inputs are 0/1.
- Signed overflow (internal):
  - ovf = c[WIDTH] ^ c[WIDTH-1].
  - For WIDTH=1, c[0] = cin, so ovf = cout ^ cin.
- Register stage:
  - rst_n low: sum_q, cout_q and ovf_q go to 0 immediately, with no clock required.
  - While rst_n is low, the registers hold 0 regardless of clk and en.
  - The first capture happens at the first rising clk edge after rst_n deasserts.
  - On a rising clk edge with rst_n high and en=1: sum_q<=sum, cout_q<=cout, ovf_q<=ovf.
  - On a rising clk edge with en=0: all registered outputs hold their values.
  - Registered-path latency is 1 cycle from the input sample to the _q outputs.
  - rst_n asserted mid-operation: the _q outputs clear asynchronously. The combinational sum and cout keep tracking the inputs.
- Boundary conditions:
  - All-ones + all-ones + cin=1 gives sum = all-ones, cout=1.
  - All-zeros with cin=0 gives sum=0, cout=0.
  - cin=1 with a = all-ones, b=0 causes a full carry ripple: sum=0, cout=1.
- No internal state other than the three output registers. No latches.

Test Plan:
- Exhaustive truth table at WIDTH=1, each combination held 10 time units.
  - Stimulus (a,b,cin) stepped 000,001,010,011,100,101,110,111.
  - Required (sum,cout): 00,10,10,01,10,01,01,11.
  - All rows must match with zero delay; ignore clk and rst_n.
- Async reset:
  - Set a=1, b=1, cin=1, en=1 and clock once, so sum_q=1, cout_q=1.
  - Drop rst_n between clock edges -> sum_q=0, cout_q=0, ovf_q=0 immediately.
  - Meanwhile sum=1 and cout=1 must stay unchanged.
- Enable hold:
  - Capture a=0, b=1, cin=0 with en=1 -> sum_q=1, cout_q=0.
  - Then set a=1, b=1, cin=1 with en=0 and clock 3 edges -> sum_q=1, cout_q=0 unchanged.
  - Raise en and clock one edge -> sum_q=1, cout_q=1.
- Overflow at WIDTH=1:
  - a=1, b=1, cin=0, en=1, one clock -> cout_q=1, ovf_q=1.
  - a=0, b=0, cin=1, one clock -> sum_q=1, cout_q=0, ovf_q=1.
- Wide ripple at WIDTH=8:
  - a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
  - a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf_q=1 after one enabled clock.
- Random regression: 1000 random (a,b,cin) vectors at WIDTH=1 and WIDTH=8 -> {cout,sum} equals a+b+cin on every vector.
